xadc_drp_arbiter: RTL and testbench

Shares the XADC Dynamic Reconfiguration Port between several independent masters, e.g. the continuous sensor poller and the register-access path that reads and writes alarm thresholds. It runs round-robin arbitration and issues exactly one single-cycle DEN strobe per granted transaction. It returns DO data to the winning requester, or an error if DRDY does not arrive within a bounded window. It sits between the requesters and the XADC primitive's DRP pins, in the dclk domain.

---
 rtl/xadc_drp_arbiter.sv | 108 ++++++++++
 tb/tb_xadc_drp_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter: round-robin sharing of the XADC DRP between NREQ masters.
// Each grant issues one DEN strobe and waits for DRDY or a bounded timeout.
module xadc_drp_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic                 dclk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [16*NREQ-1:0]   req_di,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 drp_den,
  output logic                 drp_dwe,
  output logic [6:0]           drp_daddr,
  output logic [15:0]          drp_di,
  input  logic [15:0]          drp_do,
  input  logic                 drp_drdy,
  output logic                 busy,
  output logic [7:0]           timeout_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;    // last granted requester, also owner of the open transaction
  logic [PW-1:0]  win;
  logic           found;
  logic [7:0]     timer;

  // Round-robin search starting just above the last grant, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign busy = (state == WAIT);

  // Arbitration / DRP transaction FSM; all handshake outputs are registered pulses.
  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= PW'(NREQ - 1);
      timer         <= 8'd0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= 16'd0;
      rsp_err       <= 1'b0;
      drp_den       <= 1'b0;
      drp_dwe       <= 1'b0;
      drp_daddr     <= 7'd0;
      drp_di        <= 16'd0;
      timeout_count <= 8'd0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      drp_den   <= 1'b0;
      case (state)
        IDLE: begin
          // DRDY seen here is stale (e.g. after a timeout) and is ignored.
          if (found) begin
            drp_dwe   <= req_we[win];
            drp_daddr <= req_addr[7*int'(win) +: 7];
            drp_di    <= req_di[16*int'(win) +: 16];
            drp_den   <= 1'b1;
            req_ready <= ONE << win;
            ptr       <= win;
            timer     <= 8'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (drp_drdy) begin
            rsp_valid <= ONE << ptr;
            rsp_data  <= drp_do;
            drp_dwe   <= 1'b0;
            state     <= IDLE;
          end else if (timer == 8'(TIMEOUT)) begin
            rsp_valid <= ONE << ptr;
            rsp_data  <= 16'd0;
            rsp_err   <= 1'b1;
            drp_dwe   <= 1'b0;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            state     <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Directed bench for xadc_drp_arbiter with a cycle-stepped XADC DRDY model.
module tb_xadc_drp_arbiter;

  localparam int NREQ = 2;
  localparam int TO   = 63;

  logic        dclk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [13:0] req_addr;
  logic [31:0] req_di;
  logic [15:0] rsp_data, drp_di, drp_do;
  logic        rsp_err, drp_den, drp_dwe, drp_drdy, busy;
  logic [6:0]  drp_daddr;
  logic [7:0]  timeout_count;

  int n_chk = 0;
  int n_fail = 0;

  xadc_drp_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .dclk(dclk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_di(req_di),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rspv"},  rsp_valid, 0);
    chk({tag, "_data"},  rsp_data, 0);
    chk({tag, "_err"},   rsp_err, 0);
    chk({tag, "_den"},   drp_den, 0);
    chk({tag, "_dwe"},   drp_dwe, 0);
    chk({tag, "_addr"},  drp_daddr, 0);
    chk({tag, "_di"},    drp_di, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_tocnt"}, timeout_count, 0);
  endtask

  // One transaction from an IDLE cycle. lat = cycles after the DEN cycle until
  // DRDY (0 = DRDY during DEN); lat < 0 means the model never answers.
  task automatic xact(input string tag, input int i, input logic we, input logic [6:0] a,
                      input logic [15:0] d, input int lat, input logic [15:0] dov);
    int cyc, dens, busys, rsp_at, exp_at;
    logic to;
    to     = (lat < 0 || lat > TO);
    exp_at = to ? TO + 2 : lat + 2;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[7*i +: 7]  = a;
    req_di[16*i +: 16]  = d;
    cyc = 0; dens = 0; busys = 0; rsp_at = -1;
    while (rsp_at < 0 && cyc < 400) begin
      @(negedge dclk);
      cyc++;
      drp_drdy = 1'b0;
      if (cyc == 1) begin
        chk({tag, "_ready"}, req_ready, 1 << i);
        chk({tag, "_den1"},  drp_den, 1);
        chk({tag, "_addr"},  drp_daddr, a);
        chk({tag, "_di"},    drp_di, d);
        chk({tag, "_dwe"},   drp_dwe, we);
        req_valid[i] = 1'b0;
      end
      if (drp_den) dens++;
      if (busy) busys++;
      if (|rsp_valid) begin
        rsp_at = cyc;
        chk({tag, "_rspv"},  rsp_valid, 1 << i);
        chk({tag, "_rdata"}, rsp_data, to ? 16'h0 : dov);
        chk({tag, "_rerr"},  rsp_err, to);
        chk({tag, "_dwe0"},  drp_dwe, 0);
      end else if (!to && cyc == lat + 1) begin
        drp_drdy = 1'b1;
        drp_do   = dov;
      end
    end
    drp_drdy = 1'b0;
    chk({tag, "_rsp_at"}, rsp_at, exp_at);
    chk({tag, "_dens"},   dens, 1);
    chk({tag, "_busy"},   busys, exp_at - 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_di = '0;
    drp_do = '0; drp_drdy = 1'b0;
    #1;
    chk_zero("rst");
    repeat (2) @(negedge dclk);
    reset = 1'b0;
    @(negedge dclk);

    // Single read, DO two cycles after DEN.
    xact("rd", 0, 1'b0, 7'h00, 16'h0000, 2, 16'h9A3A);
    @(negedge dclk);
    chk("rd_pulse_rspv", rsp_valid, 0);
    chk("rd_pulse_err",  rsp_err, 0);
    chk("rd_hold_data",  rsp_data, 16'h9A3A);
    chk("rd_idle_busy",  busy, 0);

    // Write from requester 1.
    xact("wr", 1, 1'b1, 7'h50, 16'hB5ED, 1, 16'h1234);
    @(negedge dclk);
    chk("wr_hold_addr", drp_daddr, 7'h50);
    chk("wr_hold_di",   drp_di, 16'hB5ED);
    chk("wr_dwe_low",   drp_dwe, 0);

    // Timeout, then a late DRDY in IDLE, then a normal read.
    xact("to", 0, 1'b0, 7'h10, 16'h0, -1, 16'h0);
    chk("to_cnt1", timeout_count, 1);
    drp_drdy = 1'b1; drp_do = 16'hFFFF;
    @(negedge dclk);
    drp_drdy = 1'b0;
    chk("late_busy", busy, 0);
    @(negedge dclk);
    chk("late_rspv", rsp_valid, 0);
    chk("late_data", rsp_data, 16'h0);
    xact("after_to", 1, 1'b0, 7'h11, 16'h0, 3, 16'h0ABC);

    // DRDY in the cycle where timer == TIMEOUT is a normal completion.
    xact("edge", 0, 1'b0, 7'h12, 16'h0, TO, 16'h5555);
    chk("edge_cnt", timeout_count, 1);

    // Saturation of the timeout counter.
    for (int n = 0; n < 300; n++) xact("sat", n % 2, 1'b0, 7'h13, 16'h0, -1, 16'h0);
    chk("sat_cnt", timeout_count, 8'hFF);

    // Round-robin with both requesters held continuously after reset.
    reset = 1'b1;
    @(negedge dclk);
    reset = 1'b0;
    req_addr = {7'h21, 7'h20}; req_we = 2'b00; req_valid = 2'b11;
    begin
      int g, cyc, since, pend;
      logic [1:0] exp_g;
      g = 0; cyc = 0; since = 0; pend = 0; exp_g = 2'b01;
      while (g < 4 && cyc < 100) begin
        @(negedge dclk);
        cyc++;
        drp_drdy = 1'b0;
        if (|rsp_valid) pend = 0;
        if (drp_den) begin
          chk("rr_overlap", pend, 0);
          pend = 1; since = 0;
          chk("rr_grant", req_ready, exp_g);
          chk("rr_addr", drp_daddr, exp_g[0] ? 7'h20 : 7'h21);
          exp_g = ~exp_g;
          g++;
          if (g == 4) req_valid = 2'b00;
        end
        if (pend != 0 && since == 1) begin drp_drdy = 1'b1; drp_do = 16'h00AA; end
        if (pend != 0) since++;
      end
      drp_drdy = 1'b0;
      chk("rr_count", g, 4);
    end

    // Asynchronous reset during the DEN cycle of a write from requester 0.
    reset = 1'b1;
    @(negedge dclk);
    reset = 1'b0;
    req_valid = 2'b01; req_we = 2'b01; req_addr = {7'h00, 7'h33}; req_di = 32'h0000_7777;
    @(negedge dclk);
    chk("mr_den",  drp_den, 1);
    chk("mr_dwe",  drp_dwe, 1);
    chk("mr_busy", busy, 1);
    req_valid = 2'b00;
    #1 reset = 1'b1;
    #1;
    chk_zero("mr");
    @(negedge dclk);
    drp_drdy = 1'b1; drp_do = 16'hBEEF;
    reset = 1'b0;
    @(negedge dclk);
    drp_drdy = 1'b0;
    chk("mr_no_rsp",  rsp_valid, 0);
    chk("mr_no_busy", busy, 0);
    req_valid = 2'b11; req_we = 2'b00;
    @(negedge dclk);
    chk("mr_first", req_ready, 2'b01);
    req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
